// File: rtl/arbitro_rr_if.sv
`default_nettype none
// ============================================================================
// Module      : arbitro_rr_if
// Description : Request/grant bundle between requesters and the round-robin
//               arbiter. The arbiter takes the slave view; the requester
//               side (or a bench) takes the master view.
// Revision    : 1.0 - initial release
// ============================================================================
interface arbitro_rr_if;
  logic [7:0] req;        // requester i drives bit (7-i)
  logic       liberar;    // release strobe from the current grantee
  logic [7:0] gnt;        // one-hot grant, index i on bit (7-i)
  logic [2:0] gnt_idx;    // binary grantee index
  logic       gnt_valid;  // a grant is active
  logic       timeout;    // tenure ended by the hold limit

  modport master (
    output req,
    output liberar,
    input  gnt,
    input  gnt_idx,
    input  gnt_valid,
    input  timeout
  );

  modport slave (
    input  req,
    input  liberar,
    output gnt,
    output gnt_idx,
    output gnt_valid,
    output timeout
  );
endinterface
`default_nettype wire

// File: rtl/arbitro_rr.sv
`default_nettype none
// ============================================================================
// Module      : arbitro_rr
// Description : 8-way round-robin arbiter with bounded tenure. A grant lasts
//               until release, request drop or MAX_HOLD cycles, followed by
//               one GAP cycle and one IDLE cycle before the next grant.
// Revision    : 1.0 - initial release
// ============================================================================
module arbitro_rr #(
  parameter int MAX_HOLD = 16   // 1..255 consecutive grant cycles
) (
  input  logic         clk,
  input  logic         rst_n,
  arbitro_rr_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic [7:0] c_max_hold = 8'(MAX_HOLD);

  state_t     r_state, w_state_nxt;
  logic [2:0] r_ptr,   w_ptr_nxt;
  logic [7:0] r_cnt,   w_cnt_nxt;
  logic [2:0] r_idx,   w_idx_nxt;
  logic       r_valid, w_valid_nxt;
  logic       r_to,    w_to_nxt;
  logic [7:0] r_gnt,   w_gnt_nxt;

  logic       w_found;
  logic [2:0] w_sel;
  logic [2:0] w_cand;
  logic       w_own_req;
  logic       w_hold_end;

  // Rotating search: first asserted request starting just after the last grantee
  always_comb begin
    w_found = 1'b0;
    w_sel   = 3'd0;
    w_cand  = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      w_cand = r_ptr + 3'(k);
      if (!w_found && bus.req[3'd7 - w_cand]) begin
        w_found = 1'b1;
        w_sel   = w_cand;
      end
    end
  end

  assign w_own_req  = bus.req[3'd7 - r_idx];
  assign w_hold_end = (r_cnt == c_max_hold);

  // Next-state and next-output logic; outputs are all taken from flops
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_valid_nxt = r_valid;
    w_gnt_nxt   = r_gnt;
    w_to_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_GRANT;
          w_ptr_nxt   = w_sel;
          w_cnt_nxt   = 8'd1;
          w_idx_nxt   = w_sel;
          w_valid_nxt = 1'b1;
          w_gnt_nxt   = 8'h80 >> w_sel;
        end
      end
      ST_GRANT: begin
        if (bus.liberar || !w_own_req || w_hold_end) begin
          w_state_nxt = ST_GAP;
          w_idx_nxt   = 3'd0;
          w_valid_nxt = 1'b0;
          w_gnt_nxt   = 8'h00;
          // Only a pure hold-limit expiry counts as a timeout
          w_to_nxt    = w_hold_end && !bus.liberar && w_own_req;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      ST_GAP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = 3'd0;
        w_valid_nxt = 1'b0;
        w_gnt_nxt   = 8'h00;
      end
    endcase
  end

  // State and output registers; ptr=7 at reset gives requester 0 first turn
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= 3'd7;
      r_cnt   <= 8'd0;
      r_idx   <= 3'd0;
      r_valid <= 1'b0;
      r_to    <= 1'b0;
      r_gnt   <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_valid <= w_valid_nxt;
      r_to    <= w_to_nxt;
      r_gnt   <= w_gnt_nxt;
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.gnt_idx   = r_idx;
  assign bus.gnt_valid = r_valid;
  assign bus.timeout   = r_to;

endmodule
`default_nettype wire

// File: doc/arbitro_rr.md
ARBITRO_RR -- requirements
Module: arbitro_rr

Interface
REQ-001 The block SHALL have one parameter: MAX_HOLD, default 16, maximum consecutive grant cycles per tenure, legal range 1..255.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 req  input  8  request lines; requester i drives bit (7-i), so MSB is requester 0.
REQ-005 liberar  input  1  release strobe from the current grantee; sampled only in GRANT.
REQ-006 gnt  output  8  one-hot grant, decoder encoding: index i drives bit (7-i) (idx 0 -> 8'b10000000, idx 7 -> 8'b00000001); 8'b0 when no grant.
REQ-007 gnt_idx  output  3  binary index of the current grantee; valid only while gnt_valid=1.
REQ-008 gnt_valid  output  1  high while a grant is active.
REQ-009 timeout  output  1  one-cycle pulse when a tenure is ended by MAX_HOLD.

Function
REQ-010 The FSM SHALL have three states: IDLE, GRANT and GAP.
REQ-011 IDLE: if req != 0, the FSM SHALL select the first requester with an asserted req, searching from (ptr+1) mod 8 upward with wrap 7->0, and SHALL enter GRANT on the next edge.
REQ-012 IDLE: if req == 0, the FSM SHALL stay in IDLE with gnt=0 and gnt_valid=0.
REQ-013 Latency: a request seen in IDLE at edge N SHALL produce gnt/gnt_valid registered high after edge N+1, i.e. visible one cycle after sampling.
REQ-014 All outputs SHALL be registered; gnt SHALL always equal the decode of gnt_idx when gnt_valid=1, else 0.
REQ-015 On entering GRANT, the hold counter (8 bits) SHALL load 1 and ptr SHALL be set to the granted index.
REQ-016 GRANT: each cycle with no exit condition, the counter SHALL increment; gnt SHALL be held unchanged.
REQ-017 GRANT exit conditions, evaluated in priority order: (a) liberar=1; (b) grantee's req bit=0; (c) counter == MAX_HOLD.
REQ-018 On any exit, the FSM SHALL go to GAP, and gnt, gnt_idx and gnt_valid SHALL clear on that edge.
REQ-019 timeout SHALL pulse for exactly one cycle, coincident with the GAP cycle, only when exit is by (c) and neither (a) nor (b) is true in the same cycle.
REQ-020 GAP SHALL last exactly one cycle with gnt=0 and then go to IDLE; this guarantees at least one idle cycle between tenures.
REQ-021 Fairness: because ptr holds the last grantee, the just-served requester SHALL have lowest priority in the next arbitration.
REQ-022 A sole requester that holds req continuously SHALL be re-granted after the GAP and IDLE cycles: MAX_HOLD grant cycles, then 2 cycles without grant, repeating.
REQ-023 Changes on req bits of non-grantees during GRANT SHALL have no effect until the next IDLE.
REQ-024 With MAX_HOLD=1, every tenure SHALL last exactly one cycle.
REQ-025 liberar asserted in IDLE or GAP SHALL be ignored.

Reset
REQ-026 While rst_n=0, regardless of clk: state=IDLE, ptr=7 (so requester 0 has first priority), counter=0, gnt=8'b0, gnt_idx=0, gnt_valid=0, timeout=0.
REQ-027 Reset asserted mid-tenure SHALL drop gnt immediately (asynchronously) with no timeout pulse; after release of reset, arbitration SHALL restart from ptr=7.

Verification
REQ-028 Reset release with req=8'b10000001 -> 1 cycle later gnt=8'b10000000, gnt_idx=0; after liberar, GAP, then gnt=8'b00000001, gnt_idx=7.
REQ-029 Round robin: req=8'hFF held, liberar pulsed each tenure -> gnt_idx sequence 0,1,2,...,7,0 with exactly one gnt=0 GAP cycle and one IDLE cycle between grants.
REQ-030 Timeout: MAX_HOLD=4, only requester 3 (req=8'b00010000) held -> gnt=8'b00010000 for 4 cycles, timeout=1 in the following cycle, then re-grant 2 cycles later.
REQ-031 Simultaneous events: liberar=1 on the same cycle the counter reaches MAX_HOLD -> tenure ends and timeout stays 0.
REQ-032 Grantee drops req mid-tenure (requester 5, req 8'b00000100 -> 0) -> gnt clears on the next edge with no timeout; pending requester 6 granted after GAP and IDLE.
REQ-033 rst_n pulsed low during GRANT of requester 2 -> gnt=0 without waiting for clk; with req=8'b00100001 after reset, requester 2 is granted before requester 7.
